// File: rtl/cpu_defs.sv
// Shared core definitions: next-PC mux codes (also used by branch control),
// reset/trap addresses and the redirect controller's state codes.
package cpu_defs;

    typedef enum logic [1:0] {
        NPC_PLUS4      = 2'b00,
        NPC_PC_OFFSET  = 2'b01,
        NPC_REG_OFFSET = 2'b10,
        NPC_INTERRUPT  = 2'b11
    } npc_sel_e;

    typedef enum logic {
        ST_RUN  = 1'b0,
        ST_TRAP = 1'b1
    } npc_state_e;

    localparam logic [31:0] RESET_PC_DEF = 32'h0000_0000;
    localparam logic [31:0] TRAP_VEC_DEF = 32'h0000_1C00;

endpackage

// File: rtl/npc_sel.sv
// Combinational priority resolution for the fetch PC: EX redirect / sync trap /
// mret, then interrupt, then stall, then sequential advance.
module npc_sel
    import cpu_defs::*;
#(
    parameter logic [31:0] TRAP_VEC = TRAP_VEC_DEF
) (
    input  logic        rst_i,
    input  logic        in_trap_i,
    input  logic [31:0] pc_i,
    input  logic [31:0] epc_i,
    input  logic        ex_valid_i,
    input  logic [1:0]  npc_mux_sel_i,
    input  logic [31:0] pc_offset_i,
    input  logic [31:0] reg_offset_i,
    input  logic [31:0] ex_pc_i,
    input  logic        ex_mret_i,
    input  logic        id_valid_i,
    input  logic [31:0] id_pc_i,
    input  logic        stall_i,
    input  logic        irq_i,
    output logic [31:0] npc_o,
    output logic        flush_o,
    output logic        epc_ld_o,
    output logic [31:0] epc_d_o,
    output logic        to_trap_o,
    output logic        to_run_o,
    output logic        irq_take_o
);

    logic redir_pc, redir_reg, sync_trap, mret_take, ex_event;

    assign redir_pc   = ex_valid_i && (npc_mux_sel_i == NPC_PC_OFFSET);
    assign redir_reg  = ex_valid_i && (npc_mux_sel_i == NPC_REG_OFFSET);
    // sel INTERRUPT inside the handler degrades to PLUS4: single trap level only
    assign sync_trap  = ex_valid_i && (npc_mux_sel_i == NPC_INTERRUPT) && !in_trap_i;
    assign mret_take  = ex_valid_i && ex_mret_i && in_trap_i;
    assign ex_event   = redir_pc || redir_reg || sync_trap || mret_take;
    assign irq_take_o = irq_i && !in_trap_i && !ex_event && !stall_i && !rst_i;

    always_comb begin
        npc_o     = pc_i + 32'd4;
        epc_ld_o  = 1'b0;
        epc_d_o   = ex_pc_i + 32'd4;
        to_trap_o = 1'b0;
        to_run_o  = 1'b0;
        if (redir_pc) begin
            npc_o = {pc_offset_i[31:2], 2'b00};
        end else if (redir_reg) begin
            npc_o = {reg_offset_i[31:2], 2'b00};
        end else if (sync_trap) begin
            npc_o     = TRAP_VEC;
            epc_ld_o  = 1'b1;
            to_trap_o = 1'b1;
        end else if (mret_take) begin
            npc_o    = epc_i;
            to_run_o = 1'b1;
        end else if (irq_take_o) begin
            // resume at the oldest instruction not yet executed
            npc_o     = TRAP_VEC;
            epc_ld_o  = 1'b1;
            epc_d_o   = id_valid_i ? id_pc_i : pc_i;
            to_trap_o = 1'b1;
        end else if (stall_i) begin
            npc_o = pc_i;
        end
    end

    assign flush_o = !rst_i && (ex_event || irq_take_o);

endmodule

// File: rtl/npc_unit.sv
// Fetch PC register and redirect controller; all decisions live in npc_sel,
// this level only holds pc, epc, trap state and the irq acknowledge pulse.
module npc_unit
    import cpu_defs::*;
#(
    parameter logic [31:0] RESET_PC = RESET_PC_DEF,
    parameter logic [31:0] TRAP_VEC = TRAP_VEC_DEF
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        ex_valid,
    input  logic [1:0]  npc_mux_sel,
    input  logic [31:0] pc_offset,
    input  logic [31:0] reg_offset,
    input  logic [31:0] ex_pc,
    input  logic        ex_mret,
    input  logic        id_valid,
    input  logic [31:0] id_pc,
    input  logic        stall,
    input  logic        irq,
    output logic [31:0] pc,
    output logic        flush,
    output logic [31:0] epc,
    output logic        in_trap,
    output logic        irq_ack
);

    logic [31:0] pc_q, pc_d, epc_q, epc_d;
    npc_state_e  state_q;
    logic        irq_ack_q;
    logic        epc_ld, to_trap, to_run, irq_take;

    npc_sel #(.TRAP_VEC(TRAP_VEC)) u_sel (
        .rst_i         (rst),
        .in_trap_i     (state_q == ST_TRAP),
        .pc_i          (pc_q),
        .epc_i         (epc_q),
        .ex_valid_i    (ex_valid),
        .npc_mux_sel_i (npc_mux_sel),
        .pc_offset_i   (pc_offset),
        .reg_offset_i  (reg_offset),
        .ex_pc_i       (ex_pc),
        .ex_mret_i     (ex_mret),
        .id_valid_i    (id_valid),
        .id_pc_i       (id_pc),
        .stall_i       (stall),
        .irq_i         (irq),
        .npc_o         (pc_d),
        .flush_o       (flush),
        .epc_ld_o      (epc_ld),
        .epc_d_o       (epc_d),
        .to_trap_o     (to_trap),
        .to_run_o      (to_run),
        .irq_take_o    (irq_take)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            pc_q      <= RESET_PC;
            epc_q     <= 32'h0;
            state_q   <= ST_RUN;
            irq_ack_q <= 1'b0;
        end else begin
            pc_q      <= pc_d;
            irq_ack_q <= irq_take;
            if (epc_ld) epc_q <= epc_d;
            if (to_trap)     state_q <= ST_TRAP;
            else if (to_run) state_q <= ST_RUN;
        end
    end

    assign pc      = pc_q;
    assign epc     = epc_q;
    assign in_trap = (state_q == ST_TRAP);
    assign irq_ack = irq_ack_q;

endmodule

// File: tb/tb_npc_unit.sv
// Directed bench for npc_unit: inputs change on the falling edge, registered
// outputs are checked on the following falling edge, flush 1ns after driving.
module tb_npc_unit;

    logic        clk = 1'b0;
    logic        rst, ex_valid, ex_mret, id_valid, stall, irq;
    logic [1:0]  npc_mux_sel;
    logic [31:0] pc_offset, reg_offset, ex_pc, id_pc;
    logic [31:0] pc, epc;
    logic        flush, in_trap, irq_ack;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    npc_unit dut (
        .clk         (clk),
        .rst         (rst),
        .ex_valid    (ex_valid),
        .npc_mux_sel (npc_mux_sel),
        .pc_offset   (pc_offset),
        .reg_offset  (reg_offset),
        .ex_pc       (ex_pc),
        .ex_mret     (ex_mret),
        .id_valid    (id_valid),
        .id_pc       (id_pc),
        .stall       (stall),
        .irq         (irq),
        .pc          (pc),
        .flush       (flush),
        .epc         (epc),
        .in_trap     (in_trap),
        .irq_ack     (irq_ack)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic idle();
        ex_valid = 0; npc_mux_sel = 2'b00; ex_mret = 0;
        pc_offset = 0; reg_offset = 0; ex_pc = 0;
        id_valid = 0; id_pc = 0; stall = 0; irq = 0;
    endtask

    task automatic state(input string tag, input logic [31:0] p, input logic [31:0] e,
                         input logic t, input logic a);
        chk({tag, ".pc"}, pc, p);
        chk({tag, ".epc"}, epc, e);
        chk({tag, ".in_trap"}, {31'b0, in_trap}, {31'b0, t});
        chk({tag, ".irq_ack"}, {31'b0, irq_ack}, {31'b0, a});
    endtask

    initial begin
        idle();
        rst = 1;
        @(negedge clk); @(negedge clk);
        state("reset", 32'h0, 32'h0, 0, 0);
        chk("reset.flush", {31'b0, flush}, 32'h0);
        // flush must stay low under reset even with events presented
        ex_valid = 1; npc_mux_sel = 2'b01; pc_offset = 32'h50; irq = 1;
        #1 chk("reset.flush_gated", {31'b0, flush}, 32'h0);
        @(negedge clk);
        idle(); rst = 0;
        #1 chk("free.flush", {31'b0, flush}, 32'h0);
        state("free0", 32'h0, 32'h0, 0, 0);
        @(negedge clk) state("free1", 32'h4, 32'h0, 0, 0);
        @(negedge clk) state("free2", 32'h8, 32'h0, 0, 0);
        @(negedge clk) state("free3", 32'hC, 32'h0, 0, 0);

        // irq during stall is held off, pc holds
        stall = 1; irq = 1;
        #1 chk("stall_irq.flush", {31'b0, flush}, 32'h0);
        @(negedge clk) state("stall_irq", 32'hC, 32'h0, 0, 0);
        idle();

        // jump to 0x100
        ex_valid = 1; npc_mux_sel = 2'b01; pc_offset = 32'h100;
        #1 chk("jmp100.flush", {31'b0, flush}, 32'h1);
        @(negedge clk) chk("jmp100.pc", pc, 32'h100);
        // misaligned target, stall overridden
        pc_offset = 32'h203; stall = 1;
        #1 chk("jmp203.flush", {31'b0, flush}, 32'h1);
        @(negedge clk) state("jmp203", 32'h200, 32'h0, 0, 0);
        // JALR target
        idle(); ex_valid = 1; npc_mux_sel = 2'b10; reg_offset = 32'h43; pc_offset = 32'h999;
        #1 chk("jalr.flush", {31'b0, flush}, 32'h1);
        @(negedge clk) state("jalr", 32'h40, 32'h0, 0, 0);

        // redirect beats irq
        idle(); ex_valid = 1; npc_mux_sel = 2'b01; pc_offset = 32'h44; irq = 1;
        @(negedge clk) state("redir_irq", 32'h44, 32'h0, 0, 0);
        idle(); ex_valid = 1; npc_mux_sel = 2'b01; pc_offset = 32'h40;
        @(negedge clk) chk("back40.pc", pc, 32'h40);

        // interrupt entry, epc from ID
        idle(); id_valid = 1; id_pc = 32'h3C; irq = 1;
        #1 chk("irq.flush", {31'b0, flush}, 32'h1);
        @(negedge clk) state("irq", 32'h1C00, 32'h3C, 1, 1);
        id_pc = 32'h1BFC;
        #1 chk("irq_held.flush", {31'b0, flush}, 32'h0);
        @(negedge clk) state("irq_held", 32'h1C04, 32'h3C, 1, 0);

        // mret with irq high: mret wins, irq retaken next cycle
        ex_valid = 1; ex_mret = 1;
        #1 chk("mret.flush", {31'b0, flush}, 32'h1);
        @(negedge clk) state("mret", 32'h3C, 32'h3C, 0, 0);
        ex_valid = 0; ex_mret = 0; id_pc = 32'h38;
        #1 chk("reirq.flush", {31'b0, flush}, 32'h1);
        @(negedge clk) state("reirq", 32'h1C00, 32'h38, 1, 1);
        idle(); ex_valid = 1; ex_mret = 1;
        @(negedge clk) state("mret2", 32'h38, 32'h38, 0, 0);

        // mret in RUN ignored
        @(negedge clk) state("mret_run", 32'h3C, 32'h38, 0, 0);

        // sync trap, then sel 11 in TRAP ignored
        idle(); ex_valid = 1; npc_mux_sel = 2'b11; ex_pc = 32'h80;
        #1 chk("strap.flush", {31'b0, flush}, 32'h1);
        @(negedge clk) state("strap", 32'h1C00, 32'h84, 1, 0);
        ex_pc = 32'h90;
        #1 chk("strap2.flush", {31'b0, flush}, 32'h0);
        @(negedge clk) state("strap2", 32'h1C04, 32'h84, 1, 0);

        // redirect inside the handler to top of memory, then wrap
        idle(); ex_valid = 1; npc_mux_sel = 2'b01; pc_offset = 32'hFFFF_FFFF;
        @(negedge clk) state("top", 32'hFFFF_FFFC, 32'h84, 1, 0);
        idle();
        @(negedge clk) state("wrap", 32'h0, 32'h84, 1, 0);

        // reset mid-trap with mret pending
        rst = 1; ex_valid = 1; ex_mret = 1; irq = 1;
        #1 chk("rst_trap.flush", {31'b0, flush}, 32'h0);
        @(negedge clk) state("rst_trap", 32'h0, 32'h0, 0, 0);
        idle(); rst = 0;
        @(negedge clk) chk("post_rst.pc", pc, 32'h4);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
